// File: rtl/uart_pkg.sv
// uart_pkg: byte-receiver FSM state type and bit-timing helper shared by the UART word receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with input synchronizer and mid-bit sampling.
// byte_valid and frame_err are single-cycle, asserted in the stop-bit sample cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_t state, state_n;
  logic [2:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  logic rx_s, fall;
  // sync[1:0] is the synchronizer; sync[2] is history for edge detection
  assign rx_s = sync[1];
  assign fall = sync[2] & ~rx_s;
  assign rx_byte = sh;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      sync <= {sync[1:0], rx};
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bit_n = bit_idx;
    sh_n = sh;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = fall ? START : IDLE;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        bit_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        bit_n = bit_idx + 3'd1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        state_n = IDLE;
        byte_valid = rx_s;
        frame_err = ~rx_s;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: assembles NBYTES UART bytes into one word, first byte MSB-aligned.
// Optional inter-byte timeout enabled by defining UART_RX_WORD_TIMEOUT_EN.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 1000000,
  parameter int NBYTES = 10,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx,
  output logic [8*NBYTES-1:0] o_rx_data,
  output logic                o_rx_valid,
  output logic                o_rx_busy,
  output logic                o_frame_err,
  output logic                o_timeout
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNTW = $clog2(NBYTES + 1);
  localparam logic [CNTW-1:0] LASTB = CNTW'(NBYTES - 1);
  if (CPB < 2 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("uart_rx_word: CLK_FREQ/BAUD must be >= 2 and TIMEOUT_BITS >= 1");
  end
  logic [7:0] rx_byte;
  logic byte_valid, frame_err, byte_busy, to_hit;
  logic [8*NBYTES-1:0] word;
  logic [8*NBYTES+7:0] cat;
  logic [CNTW-1:0] count;
  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
    .clk(clk),
    .rst(rst),
    .rx(i_rx),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .frame_err(frame_err),
    .busy(byte_busy)
  );
  assign cat = {word, rx_byte};
  assign o_rx_busy = byte_busy || count != '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      count <= '0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_frame_err <= 1'b0;
      if (byte_valid) begin
        word <= count == LASTB ? '0 : cat[8*NBYTES-1:0];
        count <= count == LASTB ? '0 : count + CNTW'(1);
        if (count == LASTB) begin
          o_rx_data <= cat[8*NBYTES-1:0];
          o_rx_valid <= 1'b1;
        end
      end else if (frame_err || to_hit) begin
        word <= '0;
        count <= '0;
        o_frame_err <= frame_err;
      end
    end
  end
`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int GAP = TIMEOUT_BITS * CPB;
  localparam int GW = $clog2(GAP);
  logic [GW-1:0] gap;
  // gap counts consecutive idle cycles while a partial word is held
  assign to_hit = count != '0 && !byte_busy && gap == GW'(GAP - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap <= '0;
      o_timeout <= 1'b0;
    end else begin
      gap <= (count != '0 && !byte_busy && !to_hit) ? gap + GW'(1) : '0;
      o_timeout <= to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif
endmodule
